// File: rtl/temp_fmt_pkg.sv
// Shared types and ASCII constants for the temperature-to-ASCII frame formatter.
package temp_fmt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    EMIT
  } state_t;

  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_DOT   = 8'h2E;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  function automatic logic [3:0] frame_len(input bit emit_crlf);
    return emit_crlf ? 4'd8 : 4'd6;
  endfunction

endpackage

// File: rtl/bcd_iter_engine.sv
// Iterative shift-add-3 binary-to-BCD converter: 9-bit input, one bit per clock, 9 clocks.
module bcd_iter_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [8:0]  bin,
  output logic [11:0] bcd,
  output logic        done
);

  logic [8:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        active_q, active_d;
  logic [11:0] bcd_adj;

  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    bcd_adj  = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load) begin
      bin_d    = bin;
      bcd_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      // Adjust first, then shift the next binary MSB into the BCD LSB.
      bcd_d = {bcd_adj[10:0], bin_q[8]};
      bin_d = {bin_q[7:0], 1'b0};
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd8) begin
        active_d = 1'b0;
      end
    end
  end

  assign bcd  = bcd_q;
  assign done = active_q && (cnt_q == 4'd8);

endmodule

// File: rtl/temp_ascii_sequencer.sv
// Formats a 13-bit ADT7420 temperature word into an ASCII frame like "+025.5\r\n"
// with valid/ready handshakes towards the I2C reader and the UART.
module temp_ascii_sequencer
  import temp_fmt_pkg::*;
#(
  parameter bit EMIT_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] temp_raw,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [3:0] FrameLen = frame_len(EMIT_CRLF);
  localparam logic [2:0] LastIdx  = 3'(FrameLen - 4'd1);

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [3:0]  tenths_q, tenths_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;

  logic [12:0] mag;
  logic [7:0]  tenths_prod;
  logic        accept;
  logic        hs;
  logic        last_hs;
  logic        eng_load;
  logic [11:0] eng_bcd;
  logic        eng_done;

  function automatic logic [7:0] byte_at(input logic [2:0]  idx,
                                         input logic        sign,
                                         input logic [11:0] bcd,
                                         input logic [3:0]  tenths);
    logic [7:0] b;
    case (idx)
      3'd0:    b = sign ? ASC_MINUS : ASC_PLUS;
      3'd1:    b = ASC_ZERO + {4'd0, bcd[11:8]};
      3'd2:    b = ASC_ZERO + {4'd0, bcd[7:4]};
      3'd3:    b = ASC_ZERO + {4'd0, bcd[3:0]};
      3'd4:    b = ASC_DOT;
      3'd5:    b = ASC_ZERO + {4'd0, tenths};
      3'd6:    b = ASC_CR;
      default: b = ASC_LF;
    endcase
    return b;
  endfunction

  // 13'h1000 negates to itself, which read as unsigned is the wanted 4096.
  assign mag         = temp_raw[12] ? (~temp_raw + 13'd1) : temp_raw;
  assign tenths_prod = {4'd0, mag[3:0]} * 8'd10;
  assign accept      = in_valid && (state_q == IDLE);
  assign hs          = tx_valid_q && tx_ready;
  assign last_hs     = (state_q == EMIT) && hs && (idx_q == LastIdx);
  assign eng_load    = accept;

  bcd_iter_engine u_bcd (
    .clk  (clk),
    .rst  (rst),
    .load (eng_load),
    .bin  (mag[12:4]),
    .bcd  (eng_bcd),
    .done (eng_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = CONVERT;
      CONVERT: if (eng_done) state_d = EMIT;
      EMIT:    if (last_hs)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == IDLE);
    busy       = (state_q != IDLE);
    frame_done = last_hs;
    tx_valid   = tx_valid_q;
    tx_data    = tx_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q     <= 1'b0;
      tenths_q   <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      sign_q     <= sign_d;
      tenths_q   <= tenths_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  always_comb begin
    sign_d     = sign_q;
    tenths_d   = tenths_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    if (accept) begin
      sign_d   = temp_raw[12];
      tenths_d = tenths_prod[7:4];
      idx_d    = '0;
    end else if (state_q == EMIT) begin
      // First EMIT cycle loads byte 0; this is what fixes the 10-edge latency.
      if (!tx_valid_q) begin
        tx_valid_d = 1'b1;
        tx_data_d  = byte_at(idx_q, sign_q, eng_bcd, tenths_q);
      end else if (hs) begin
        if (idx_q == LastIdx) begin
          tx_valid_d = 1'b0;
        end else begin
          idx_d     = idx_q + 3'd1;
          tx_data_d = byte_at(idx_q + 3'd1, sign_q, eng_bcd, tenths_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_temp_ascii_sequencer.sv
// Scoreboard bench for temp_ascii_sequencer: CRLF and no-CRLF instances share clock and reset.
module tb_temp_ascii_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] temp_raw, temp_raw1;
  logic        in_valid, in_valid1;
  logic        in_ready, in_ready1;
  logic [7:0]  tx_data, tx_data1;
  logic        tx_valid, tx_valid1;
  logic        tx_ready, tx_ready1;
  logic        busy, busy1;
  logic        frame_done, frame_done1;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  logic [8:0] e0, e1;

  always #5 clk = ~clk;

  temp_ascii_sequencer #(.EMIT_CRLF(1'b1)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .temp_raw   (temp_raw),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  temp_ascii_sequencer #(.EMIT_CRLF(1'b0)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .temp_raw   (temp_raw1),
    .in_valid   (in_valid1),
    .in_ready   (in_ready1),
    .tx_data    (tx_data1),
    .tx_valid   (tx_valid1),
    .tx_ready   (tx_ready1),
    .busy       (busy1),
    .frame_done (frame_done1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (exp_q0.size() == 0) begin
        fail_now($sformatf("dut0 unexpected byte %02h", tx_data));
      end else begin
        e0 = exp_q0.pop_front();
        chk("dut0 byte", {24'd0, tx_data}, {24'd0, e0[7:0]});
        chk("dut0 frame_done", {31'd0, frame_done}, {31'd0, e0[8]});
        if (frame_done) fd_count++;
      end
    end else if (!rst && frame_done) begin
      fail_now("dut0 frame_done without handshake");
    end
  end

  always @(negedge clk) begin
    if (!rst && tx_valid1 && tx_ready1) begin
      if (exp_q1.size() == 0) begin
        fail_now($sformatf("dut1 unexpected byte %02h", tx_data1));
      end else begin
        e1 = exp_q1.pop_front();
        chk("dut1 byte", {24'd0, tx_data1}, {24'd0, e1[7:0]});
        chk("dut1 frame_done", {31'd0, frame_done1}, {31'd0, e1[8]});
      end
    end else if (!rst && frame_done1) begin
      fail_now("dut1 frame_done without handshake");
    end
  end

  task automatic push_frame(input int which, input string s, input bit crlf);
    logic [7:0] b;
    logic [8:0] item[$];
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      item.push_back({(!crlf && i == s.len() - 1), b});
    end
    if (crlf) begin
      item.push_back({1'b0, 8'h0D});
      item.push_back({1'b1, 8'h0A});
    end
    foreach (item[k]) begin
      if (which == 0) exp_q0.push_back(item[k]);
      else exp_q1.push_back(item[k]);
    end
  endtask

  task automatic accept0(input logic [12:0] w);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) fail_now("dut0 in_ready timeout");
    temp_raw = w;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid0(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!tx_valid && n < 40);
  endtask

  task automatic drain0();
    int n = 0;
    while ((exp_q0.size() != 0 || !in_ready) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) fail_now("dut0 drain timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic [12:0] vec_w[5] = '{13'h0198, 13'h1FFF, 13'h1000, 13'h0FFF, 13'h0000};
  string       vec_s[5] = '{"+025.5", "-000.0", "-256.0", "+255.9", "+000.0"};

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int lat;
    int fd_before;
    int n;
    rst = 1'b1;
    temp_raw = '0; in_valid = 1'b0; tx_ready = 1'b1;
    temp_raw1 = '0; in_valid1 = 1'b0; tx_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("reset tx_data", {24'd0, tx_data}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset frame_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      fd_before = fd_count;
      push_frame(0, vec_s[v], 1'b1);
      accept0(vec_w[v]);
      chk("busy after accept", {31'd0, busy}, 32'd1);
      wait_valid0(lat);
      chk("first byte latency", lat, 32'd10);
      drain0();
      chk("frame_done pulses", fd_count - fd_before, 32'd1);
    end

    // Backpressure on byte 3 with an ignored in_valid pulse.
    tx_ready = 1'b0;
    push_frame(0, "+025.5", 1'b1);
    accept0(13'h0198);
    wait_valid0(lat);
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tx_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("stall tx_data", {24'd0, tx_data}, 32'h35);
      chk("stall tx_valid", {31'd0, tx_valid}, 32'd1);
      chk("stall in_ready", {31'd0, in_ready}, 32'd0);
      temp_raw = 13'h0FFF;
      in_valid = (c == 2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tx_ready = 1'b1;
    drain0();
    repeat (20) @(posedge clk);
    #1;
    chk("no extra frame busy", {31'd0, busy}, 32'd0);

    // Reset during CONVERT cycle 4.
    accept0(13'h0FFF);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst convert tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst convert in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst convert busy", {31'd0, busy}, 32'd0);

    // Reset during EMIT byte 2 with tx_ready high.
    tx_ready = 1'b0;
    exp_q0.push_back({1'b0, 8'h2B});
    exp_q0.push_back({1'b0, 8'h30});
    accept0(13'h0198);
    wait_valid0(lat);
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("emit byte 2 before rst", {24'd0, tx_data}, 32'h32);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst emit tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst emit in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst emit busy", {31'd0, busy}, 32'd0);
    chk("rst emit pending", exp_q0.size(), 32'd0);
    repeat (15) @(posedge clk);
    #1;
    chk("no resume after rst", {31'd0, tx_valid}, 32'd0);

    push_frame(0, "+025.0", 1'b1);
    accept0(13'h0190);
    drain0();

    // No-terminator instance.
    push_frame(1, "+025.0", 1'b0);
    temp_raw1 = 13'h0190;
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    n = 0;
    while ((exp_q1.size() != 0 || !in_ready1) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) fail_now("dut1 drain timeout");
    repeat (20) @(posedge clk);
    #1;
    chk("dut1 idle after frame", {31'd0, busy1}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
